// File: rtl/weight_fetch_streamer.sv
// weight_fetch_streamer: read-side initiator for the weight memory array port.
// Issues one single-word read at a time (base, base+stride, ...), buffers the
// returned words in a small FIFO and streams them to the systolic array.
// Requests that go unanswered are reissued; too many in a row abort the job.
module weight_fetch_streamer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base,
  input  logic [LEN_WIDTH-1:0]  i_cfg_len,
  input  logic [ADDR_WIDTH-1:0] i_cfg_stride,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_re,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_valid,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic                  o_w_valid,
  input  logic                  i_w_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_FIN
  } stateT;

  stateT                 r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [RTY_W-1:0]      r_retry;
  logic [TMR_W-1:0]      r_timer;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_memRe;
  logic [ADDR_WIDTH-1:0] r_memAddr;

  logic [DATA_WIDTH-1:0] r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_countNext;
  logic                  w_hasSpace;
  logic [ADDR_WIDTH-1:0] w_addrNext;
  logic                  w_timeout;
  logic                  w_abort;

  // Returned data is only accepted while a request is outstanding; the space
  // check looks at the count after this cycle's push/pop so a reissue can
  // be registered in the same cycle the response lands.
  assign w_push      = (r_state == S_WAIT) && i_mem_valid;
  assign w_pop       = (r_count != '0) && i_w_ready;
  assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_hasSpace  = (w_countNext < CNT_W'(FIFO_DEPTH));
  assign w_addrNext  = r_addr + r_stride;
  assign w_timeout   = (r_state == S_WAIT) && !i_mem_valid && (r_timer == TMR_W'(TIMEOUT));
  assign w_abort     = w_timeout && (r_retry == RTY_W'(MAX_RETRY));

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_mem_re   = r_memRe;
  assign o_mem_addr = r_memAddr;
  assign o_w_valid  = (r_count != '0);
  assign o_w_data   = o_w_valid ? r_fifoMem[r_rdPtr] : '0;

  // Output FIFO: circular buffer, emptied on reset and on an aborted job.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifoMem[r_wrPtr] <= i_mem_rdata;
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count <= w_countNext;
    end
  end

  // Control FSM; a request is registered directly on the transition that
  // wants it, so mem_re appears the cycle after start or after a response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_memRe     <= 1'b0;
      r_memAddr   <= '0;
    end else begin
      r_memRe <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !r_busy) begin
            r_addr      <= i_cfg_base;
            r_stride    <= i_cfg_stride;
            r_remaining <= i_cfg_len;
            r_retry     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            if (i_cfg_len == '0) begin
              r_state <= S_FIN;
            end else if (w_hasSpace) begin
              r_memRe   <= 1'b1;
              r_memAddr <= i_cfg_base;
              r_timer   <= '0;
              r_state   <= S_WAIT;
            end else begin
              r_state <= S_ISSUE;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_hasSpace) begin
            r_memRe   <= 1'b1;
            r_memAddr <= r_addr;
            r_timer   <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_valid) begin
            r_addr      <= w_addrNext;
            r_remaining <= r_remaining - 1'b1;
            r_retry     <= '0;
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state <= S_DRAIN;
            end else if (w_hasSpace) begin
              r_memRe   <= 1'b1;
              r_memAddr <= w_addrNext;
              r_timer   <= '0;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (w_timeout) begin
            if (w_abort) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_retry <= r_retry + 1'b1;
              if (w_hasSpace) begin
                r_memRe   <= 1'b1;
                r_memAddr <= r_addr;
                r_timer   <= '0;
              end else begin
                r_state <= S_ISSUE;
              end
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_streamer.sv
// tb_weight_fetch_streamer: directed and randomized jobs against a memory
// image; expected addresses are base + i*stride (mod 2^14) and expected words
// are the image contents at those addresses.
module tb_weight_fetch_streamer;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int LW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfgBase;
  logic [LW-1:0] cfgLen;
  logic [AW-1:0] cfgStride;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] memAddr;
  logic          memRe;
  logic [DW-1:0] memRdata;
  logic          memValid;
  logic [DW-1:0] wData;
  logic          wValid;
  logic          wReady;

  always #5 clk = ~clk;

  weight_fetch_streamer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_cfg_base   (cfgBase),
    .i_cfg_len    (cfgLen),
    .i_cfg_stride (cfgStride),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_mem_addr   (memAddr),
    .o_mem_re     (memRe),
    .i_mem_rdata  (memRdata),
    .i_mem_valid  (memValid),
    .o_w_data     (wData),
    .o_w_valid    (wValid),
    .i_w_ready    (wReady)
  );

  logic [DW-1:0] memImg [0:(1<<AW)-1];
  logic [AW-1:0] reqAddrs [$];
  int            reqCycs [$];
  logic [DW-1:0] gotWords [$];
  int            doneCount = 0;
  int            reqCount = 0;
  int            cyc = 0;

  int            latency = 2;
  int            dropIdx = -1;
  int            answerUntil = 1 << 30;
  bit            randReady = 1'b0;

  int            compared = 0;
  int            mismatched = 0;
  int            rBase, wBase, dBase, startCyc;
  logic [AW-1:0] b, s;
  int            l;

  // Cycle index, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and output monitor: samples at the falling edge, drives
  // the response shortly after the rising edge.
  initial begin
    bit            pend;
    int            pendDelay;
    logic [AW-1:0] pendAddr;
    pend      = 1'b0;
    pendDelay = 0;
    pendAddr  = '0;
    memValid  = 1'b0;
    memRdata  = '0;
    forever begin
      @(negedge clk);
      if (memRe) begin
        if (reqCount != dropIdx && reqCount < answerUntil) begin
          pend      = 1'b1;
          pendAddr  = memAddr;
          pendDelay = latency;
        end
        reqAddrs.push_back(memAddr);
        reqCycs.push_back(cyc);
        reqCount++;
      end
      if (wValid && wReady) gotWords.push_back(wData);
      if (done) doneCount++;
      @(posedge clk);
      #1;
      memValid = 1'b0;
      memRdata = DW'($urandom);
      if (pend) begin
        pendDelay--;
        if (pendDelay == 0) begin
          memValid = 1'b1;
          memRdata = memImg[pendAddr];
          pend     = 1'b0;
        end
      end
    end
  end

  function automatic logic [AW-1:0] modelAddr(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int i);
    longint a;
    a = (longint'(base) + longint'(i) * longint'(stride)) % (longint'(1) << AW);
    return AW'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    rBase = reqAddrs.size();
    wBase = gotWords.size();
    dBase = doneCount;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic [AW-1:0] stride);
    startCyc  = cyc;
    start     = 1'b1;
    cfgBase   = base;
    cfgLen    = len;
    cfgStride = stride;
    step();
    start     = 1'b0;
    cfgBase   = AW'($urandom);
    cfgLen    = LW'($urandom);
    cfgStride = AW'($urandom);
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      if (randReady) wReady = 1'($urandom_range(0, 1));
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      checkOutput({tag, "_busy_at_done"}, 32'(busy), 1);
      step();
      checkOutput({tag, "_busy_after_done"}, 32'(busy), 0);
      checkOutput({tag, "_done_one_cycle"}, 32'(done), 0);
    end
  endtask

  task automatic checkAddrs(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride, input int len, input int from);
    checkOutput({tag, "_req_count"}, 32'(reqAddrs.size() - from), 32'(len));
    for (int i = 0; i < len && from + i < reqAddrs.size(); i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), 32'(reqAddrs[from+i]), 32'(modelAddr(base, stride, i)));
  endtask

  task automatic checkWords(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride, input int len, input int from);
    checkOutput({tag, "_word_count"}, 32'(gotWords.size() - from), 32'(len));
    for (int i = 0; i < len && from + i < gotWords.size(); i++)
      checkOutput($sformatf("%s_word%0d", tag, i), 32'(gotWords[from+i]), 32'(memImg[modelAddr(base, stride, i)]));
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) memImg[a] = DW'($urandom);
    rst       = 1'b1;
    start     = 1'b0;
    cfgBase   = '0;
    cfgLen    = '0;
    cfgStride = '0;
    wReady    = 1'b1;
    step();
    step();

    // Reset state
    checkOutput("rst_busy",   32'(busy), 0);
    checkOutput("rst_done",   32'(done), 0);
    checkOutput("rst_err",    32'(err), 0);
    checkOutput("rst_mem_re", 32'(memRe), 0);
    checkOutput("rst_addr",   32'(memAddr), 0);
    checkOutput("rst_wvalid", 32'(wValid), 0);
    checkOutput("rst_wdata",  32'(wData), 0);
    rst = 1'b0;
    step();

    // Basic fetch
    $display("[TB] basic fetch");
    snap();
    applyStimulus(14'h0010, 4, 1);
    checkOutput("basic_busy_T1",   32'(busy), 1);
    checkOutput("basic_re_T1",     32'(memRe), 1);
    checkOutput("basic_addr_T1",   32'(memAddr), 32'h10);
    waitDone("basic", 200);
    checkAddrs("basic", 14'h0010, 1, 4, rBase);
    checkWords("basic", 14'h0010, 1, 4, wBase);
    if (reqCycs.size() >= rBase + 2) begin
      checkOutput("basic_first_re_cycle", 32'(reqCycs[rBase] - startCyc), 1);
      checkOutput("basic_re_spacing", 32'(reqCycs[rBase+1] - reqCycs[rBase]), 3);
    end
    checkOutput("basic_err", 32'(err), 0);
    checkOutput("basic_done_count", 32'(doneCount - dBase), 1);

    // Backpressure
    $display("[TB] backpressure");
    snap();
    wReady = 1'b0;
    b = AW'($urandom);
    s = AW'($urandom_range(1, 5));
    applyStimulus(b, 8, s);
    repeat (30) step();
    checkOutput("bp_req_stalled", 32'(reqAddrs.size() - rBase), 4);
    checkOutput("bp_wvalid_full", 32'(wValid), 1);
    wReady = 1'b1;
    waitDone("bp", 300);
    checkAddrs("bp", b, s, 8, rBase);
    checkWords("bp", b, s, 8, wBase);

    // Wrap and stride
    $display("[TB] wrap");
    snap();
    applyStimulus(14'h3FFE, 3, 3);
    waitDone("wrap", 200);
    checkAddrs("wrap", 14'h3FFE, 3, 3, rBase);
    checkWords("wrap", 14'h3FFE, 3, 3, wBase);
    if (reqAddrs.size() >= rBase + 3) begin
      checkOutput("wrap_addr1_abs", 32'(reqAddrs[rBase+1]), 32'h0001);
      checkOutput("wrap_addr2_abs", 32'(reqAddrs[rBase+2]), 32'h0004);
    end

    // Dropped request on word 1
    $display("[TB] dropped request");
    snap();
    dropIdx = rBase + 1;
    b = AW'($urandom);
    s = AW'($urandom_range(1, 100));
    applyStimulus(b, 4, s);
    waitDone("drop", 300);
    dropIdx = -1;
    checkOutput("drop_req_count", 32'(reqAddrs.size() - rBase), 5);
    if (reqAddrs.size() >= rBase + 5) begin
      checkOutput("drop_first_addr", 32'(reqAddrs[rBase+1]), 32'(modelAddr(b, s, 1)));
      checkOutput("drop_reissue_addr", 32'(reqAddrs[rBase+2]), 32'(modelAddr(b, s, 1)));
      checkOutput("drop_reissue_gap", 32'(reqCycs[rBase+2] - reqCycs[rBase+1]), 9);
      checkOutput("drop_next_addr", 32'(reqAddrs[rBase+3]), 32'(modelAddr(b, s, 2)));
    end
    checkWords("drop", b, s, 4, wBase);
    checkOutput("drop_err", 32'(err), 0);

    // Abort: words 0 and 1 buffered, word 2 never answered
    $display("[TB] abort");
    snap();
    wReady = 1'b0;
    answerUntil = rBase + 2;
    b = AW'($urandom);
    s = AW'($urandom_range(1, 200));
    applyStimulus(b, 5, s);
    waitDone("abort", 400);
    checkOutput("abort_err", 32'(err), 1);
    checkOutput("abort_req_count", 32'(reqAddrs.size() - rBase), 6);
    if (reqAddrs.size() >= rBase + 6) begin
      for (int k = 2; k < 6; k++)
        checkOutput($sformatf("abort_addr%0d", k), 32'(reqAddrs[rBase+k]), 32'(modelAddr(b, s, 2)));
      checkOutput("abort_retry_gap", 32'(reqCycs[rBase+5] - reqCycs[rBase+4]), 9);
    end
    checkOutput("abort_wvalid", 32'(wValid), 0);
    checkOutput("abort_done_count", 32'(doneCount - dBase), 1);
    answerUntil = 1 << 30;
    wReady = 1'b1;
    step();
    checkOutput("abort_no_words", 32'(gotWords.size() - wBase), 0);
    snap();
    b = AW'($urandom);
    applyStimulus(b, 2, 1);
    checkOutput("abort_err_cleared", 32'(err), 0);
    waitDone("after_abort", 200);
    checkWords("after_abort", b, 1, 2, wBase);

    // Reset mid-WAIT with two buffered words and a late response
    $display("[TB] reset mid-transfer");
    snap();
    wReady = 1'b0;
    latency = 4;
    b = AW'($urandom);
    s = AW'($urandom_range(1, 50));
    applyStimulus(b, 8, s);
    for (int i = 0; i < 100; i++) begin
      if (reqAddrs.size() - rBase >= 3) break;
      step();
    end
    checkOutput("rstmid_third_req", 32'(reqAddrs.size() - rBase), 3);
    checkOutput("rstmid_pre_wvalid", 32'(wValid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstmid_busy",   32'(busy), 0);
    checkOutput("rstmid_done",   32'(done), 0);
    checkOutput("rstmid_err",    32'(err), 0);
    checkOutput("rstmid_mem_re", 32'(memRe), 0);
    checkOutput("rstmid_addr",   32'(memAddr), 0);
    checkOutput("rstmid_wvalid", 32'(wValid), 0);
    checkOutput("rstmid_wdata",  32'(wData), 0);
    repeat (6) step();
    checkOutput("rstmid_late_valid_wvalid", 32'(wValid), 0);
    checkOutput("rstmid_no_new_req", 32'(reqAddrs.size() - rBase), 3);
    checkOutput("rstmid_no_done", 32'(doneCount - dBase), 0);
    latency = 2;
    wReady = 1'b1;

    // Start while busy is ignored
    $display("[TB] start while busy");
    snap();
    b = AW'($urandom);
    s = AW'($urandom_range(1, 500));
    applyStimulus(b, 4, s);
    step();
    start     = 1'b1;
    cfgBase   = ~b;
    cfgLen    = 9;
    cfgStride = s + 1'b1;
    step();
    start = 1'b0;
    waitDone("busy_start", 300);
    repeat (5) step();
    checkAddrs("busy_start", b, s, 4, rBase);
    checkWords("busy_start", b, s, 4, wBase);
    checkOutput("busy_start_done_count", 32'(doneCount - dBase), 1);

    // Zero-length job
    $display("[TB] zero length");
    snap();
    applyStimulus(AW'($urandom), 0, AW'($urandom));
    checkOutput("len0_busy_T1", 32'(busy), 1);
    checkOutput("len0_re_T1", 32'(memRe), 0);
    checkOutput("len0_done_T1", 32'(done), 0);
    step();
    checkOutput("len0_done_T2", 32'(done), 1);
    checkOutput("len0_busy_T2", 32'(busy), 1);
    step();
    checkOutput("len0_busy_T3", 32'(busy), 0);
    checkOutput("len0_no_req", 32'(reqAddrs.size() - rBase), 0);

    // Randomized jobs with random latency and random consumer backpressure
    $display("[TB] random jobs");
    for (int t = 0; t < 6; t++) begin
      snap();
      b = AW'($urandom);
      s = AW'($urandom);
      l = $urandom_range(1, 12);
      latency = $urandom_range(1, 6);
      randReady = 1'b1;
      applyStimulus(b, LW'(l), s);
      waitDone($sformatf("rand%0d", t), 2000);
      randReady = 1'b0;
      wReady = 1'b1;
      checkAddrs($sformatf("rand%0d", t), b, s, l, rBase);
      checkWords($sformatf("rand%0d", t), b, s, l, wBase);
      checkOutput($sformatf("rand%0d_err", t), 32'(err), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/weight_fetch_streamer.md
# weight_fetch_streamer

Read-side initiator for the weight memory controller's array port. On a start command it issues one single-word read per weight from `cfg_base` for `cfg_len` words, stepping by `cfg_stride`. Returned words are buffered in a small FIFO and streamed to the systolic array over a valid/ready interface. It retries requests that the memory controller drops while the host port has priority.

## Interface

Parameters:
- `ADDR_WIDTH`, 14, weight memory word-address width.
- `DATA_WIDTH`, 16, weight word width.
- `LEN_WIDTH`, 15, width of the word-count field; max transfer is 2^LEN_WIDTH−1 words.
- `FIFO_DEPTH`, 4, output buffer entries; power of two, ≥2.
- `TIMEOUT`, 8, WAIT cycles without `mem_valid` before a request is reissued.
- `MAX_RETRY`, 3, consecutive timeouts on one word before abort.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle command strobe; ignored unless `busy`=0.
- `cfg_base`  input  ADDR_WIDTH  first word address, sampled on accepted `start`.
- `cfg_len`  input  LEN_WIDTH  number of words, sampled on accepted `start`.
- `cfg_stride`  input  ADDR_WIDTH  address increment per word, sampled on accepted `start`.
- `busy`  output  1  high from the cycle after accepted `start` until the cycle `done` pulses, inclusive.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  sticky abort flag; cleared on next accepted `start` or `rst`.
- `mem_addr`  output  ADDR_WIDTH  read address to the memory controller array port.
- `mem_re`  output  1  one-cycle read request pulse.
- `mem_rdata`  input  DATA_WIDTH  read data.
- `mem_valid`  input  1  read data strobe.
- `w_data`  output  DATA_WIDTH  FIFO head word.
- `w_valid`  output  1  FIFO not empty.
- `w_ready`  input  1  array consumes head when `w_valid` & `w_ready`.

## Operation

- States: IDLE, ISSUE, WAIT, DRAIN, FIN.
- IDLE:
  - On `start`: latch config, set `addr`=`cfg_base`, `remaining`=`cfg_len`, `retry`=0, and clear `err`.
  - Go to ISSUE, or to FIN if `cfg_len`=0.
- ISSUE:
  - If FIFO count < `FIFO_DEPTH`, pulse `mem_re` with `mem_addr`=`addr` and go to WAIT.
  - Otherwise stall in ISSUE with `mem_re`=0.
- WAIT:
  - At most one request is outstanding.
  - On `mem_valid`: push `mem_rdata` into the FIFO, `addr` ← `addr`+`cfg_stride` (mod 2^ADDR_WIDTH, wraps silently), `remaining`−1, and `retry`=0.
  - After a push, go to DRAIN if `remaining` becomes 0, else to ISSUE.
  - Timeout counter increments each WAIT cycle without `mem_valid`. On reaching `TIMEOUT`:
    - If `retry` < `MAX_RETRY`: `retry`+1, back to ISSUE with the same `addr`.
    - Otherwise: set `err`, flush the FIFO, go to FIN.
- DRAIN: wait for the FIFO to empty, then go to FIN.
- FIN: pulse `done` for one cycle, then go to IDLE. `busy` drops the cycle after FIN.
- `mem_valid` outside WAIT is discarded and does not alter the FIFO.
- FIFO:
  - Simultaneous push and pop are both performed; count is unchanged.
  - A pop when empty is ignored.
  - A push is never issued when full, which the ISSUE space check guarantees.
- `start` while `busy`=1 is ignored, and config is not re-sampled.
- `rst` in any state:
  - State returns to IDLE and the FIFO empties.
  - Counters, `retry`, `err`, `done`, `busy`, `mem_re`, `mem_addr`, `w_valid` and `w_data` all go to 0.
  - A late `mem_valid` after reset is discarded.

## Timing

- All outputs are registered except `w_valid`/`w_data`, which are decoded from registered FIFO state.
- Accepted `start` at cycle T: `busy`=1 and `mem_re`=1 at T+1.
- `mem_valid` at cycle V: `w_valid`=1 at V+1 (if the FIFO was empty), and the next `mem_re` at V+1 if space exists.
- With 2-cycle memory latency (`mem_re` at C, `mem_valid` at C+2), steady state is one word per 3 cycles.
- The timeout is measured from the cycle after `mem_re`: reissue occurs `TIMEOUT`+1 cycles after the original pulse.
- `cfg_len`=0: `done` at T+2, and no `mem_re` is issued.

## Test plan

- Basic fetch: base=0x0010, len=4, stride=1, 2-cycle responder, `w_ready`=1.
  - `mem_addr` sequence 0x10, 0x11, 0x12, 0x13; four words out in order.
  - One `done` pulse, `err`=0.
- Backpressure: len=8, `w_ready`=0 for 30 cycles.
  - Exactly 4 `mem_re` issued and then stall.
  - After releasing `w_ready`, all 8 words are delivered in order with no loss or duplication.
- Wrap and stride: base=0x3FFE, stride=3, len=3.
  - Addresses 0x3FFE, 0x0001, 0x0004.
- Dropped request: responder ignores the first `mem_re` of word 1.
  - Reissue at the same address 9 cycles later; data correct; `err`=0.
- Abort: responder never answers.
  - 4 `mem_re` pulses at one address, then `err`=1 and `done` pulse.
  - `w_valid`=0; next `start` clears `err`.
- Reset and ignore cases:
  - `rst` asserted mid-WAIT with 2 FIFO entries: all outputs 0 next cycle, and a late `mem_valid` is ignored.
  - `start` while busy: no effect.
  - len=0: `done` at T+2 with no `mem_re`.
